mdu_unit: RTL and testbench

- Multiply/divide unit for the 5-stage pipelined MIPS CPU, sitting in the E stage beside the ALU.
- Owns the HI/LO registers and executes mult/multu/div/divu/mthi/mtlo.
- Drives the busy/occupancy request that the hazard/stall controller consumes: it is the producer side of the MD stall handshake.
- mfhi/mflo read hi_out/lo_out through the existing E-stage result mux.

---
 rtl/mdu_unit_pkg.sv | 37 +++
 rtl/mdu_arith.sv | 69 ++++++
 rtl/mdu_unit.sv | 86 ++++++++
 tb/tb_mdu_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_unit_pkg.sv
// mdu_unit_pkg: MDU op codes and op-class helpers shared by the
// decoder, the hazard unit and the multiply/divide unit.
// Optional macro MDU_MADD_EN adds the madd/maddu/msub/msubu class.
package mdu_unit_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MTHI  = 4'd4;
  localparam logic [3:0] MDU_MTLO  = 4'd5;
  localparam logic [3:0] MDU_MADD  = 4'd6;
  localparam logic [3:0] MDU_MADDU = 4'd7;
  localparam logic [3:0] MDU_MSUB  = 4'd8;
  localparam logic [3:0] MDU_MSUBU = 4'd9;

  // Accumulate family; these codes are only legal when MDU_MADD_EN is defined.
  function automatic logic is_madd_class(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == MDU_MADD) || (op == MDU_MADDU) ||
           (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
    return (op == 4'hF) && (op != 4'hF);
`endif
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Ops that occupy the unit for several cycles (IS_MD_CLASS).
  function automatic logic is_md_class(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           is_div_class(op) || is_madd_class(op);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: purely combinational 64-bit multiply/divide/accumulate
// datapath. Produces {HI,LO} for the requested op and a divide-by-zero flag.
// Optional macro MDU_MADD_EN adds the accumulate adder and old HI/LO inputs.
module mdu_arith
  import mdu_unit_pkg::*;
(
`ifdef MDU_MADD_EN
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
`endif
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div0
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quot;
  logic [31:0] rem;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes, so 0x80000000 / -1 wraps cleanly
  // to 0x80000000 instead of hitting signed-overflow behaviour.
  assign div_signed = (op == MDU_DIV);
  assign mag_a      = (div_signed && a[31]) ? (~a + 32'd1) : a;
  assign mag_b      = (div_signed && b[31]) ? (~b + 32'd1) : b;
  assign div0       = is_div_class(op) && (b == '0);

  // Unsigned core divider, guarded against a zero divisor.
  always_comb begin
    q_u = '0;
    r_u = '0;
    if (b != '0) begin
      q_u = mag_a / mag_b;
      r_u = mag_a % mag_b;
    end
  end

  assign quot = (div_signed && (a[31] ^ b[31])) ? (~q_u + 32'd1) : q_u;
  assign rem  = (div_signed && a[31]) ? (~r_u + 32'd1) : r_u;

  // Result select by op class.
  always_comb begin
    result = '0;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV,
      MDU_DIVU:  result = {rem, quot};
`ifdef MDU_MADD_EN
      MDU_MADD:  result = {hi_in, lo_in} + prod_s;
      MDU_MADDU: result = {hi_in, lo_in} + prod_u;
      MDU_MSUB:  result = {hi_in, lo_in} - prod_s;
      MDU_MSUBU: result = {hi_in, lo_in} - prod_u;
`endif
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit. Owns HI/LO, runs the busy
// counter and drives md_hazard for the MD stall handshake.
// Optional macro MDU_MADD_EN enables the madd/maddu/msub/msubu ops.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        md_hazard,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] pend;
  logic        pend_wr;
  logic [3:0]  cnt;
  logic [63:0] arith_res;
  logic        arith_div0;

  mdu_arith u_arith (
`ifdef MDU_MADD_EN
    .hi_in  (hi_q),
    .lo_in  (lo_q),
`endif
    .op     (mdu_op),
    .a      (src_a),
    .b      (src_b),
    .result (arith_res),
    .div0   (arith_div0)
  );

  // Launch, count down and commit; starts while busy are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
    end else if (busy) begin
      if (cnt == 4'd1) begin
        busy    <= 1'b0;
        pend_wr <= 1'b0;
        if (pend_wr) begin
          hi_q <= pend[63:32];
          lo_q <= pend[31:0];
        end
      end
      cnt <= cnt - 4'd1;
    end else if (start) begin
      if (is_md_class(mdu_op)) begin
        pend    <= arith_res;
        pend_wr <= ~arith_div0;
        busy    <= 1'b1;
        cnt     <= is_div_class(mdu_op) ? DIV_N : MULT_N;
      end else if (mdu_op == MDU_MTHI) begin
        hi_q <= src_a;
      end else if (mdu_op == MDU_MTLO) begin
        lo_q <= src_a;
      end
    end
  end

  // Hazard covers the launch cycle as well as the busy window.
  always_comb begin
    md_hazard = busy | (start & is_md_class(mdu_op));
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed self-checking bench for mdu_unit with a
// scoreboard queue of expected {HI,LO} results.
// Honours MDU_MADD_EN for the accumulate-op checks.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        md_hazard;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdu_op    (mdu_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .md_hazard (md_hazard),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mthi/mtlo: single-cycle write, never busy.
  task automatic run_mt(input string tag, input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; mdu_op = op; src_a = a; src_b = '0;
    #1 check({tag, "_hz"}, {63'd0, md_hazard}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    if (op == MDU_MTHI) m_hi = a; else m_lo = a;
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_hilo"}, {hi_out, lo_out}, {m_hi, m_lo});
  endtask

  // Multi-cycle op; optionally injects a stray mthi at busy cycle intrude_at.
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int n,
                        input int intrude_at);
    int          bc;
    int          hz;
    logic [63:0] got_exp;
    bc = 0;
    hz = 0;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b1; mdu_op = op; src_a = a; src_b = b;
    #1 check({tag, "_hz0"}, {63'd0, md_hazard}, 64'd1);
    if (md_hazard) hz++;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && busy; i++) begin
      bc++;
      if (md_hazard) hz++;
      check({tag, "_hold"}, {hi_out, lo_out}, {m_hi, m_lo});
      if (bc == intrude_at) begin
        start = 1'b1; mdu_op = MDU_MTHI; src_a = 32'hDEADBEEF;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check({tag, "_busycyc"}, 64'(bc), 64'(n));
    check({tag, "_hzcyc"}, 64'(hz), 64'(n + 1));
    if (sb_q.size() == 0) begin
      check({tag, "_sbempty"}, 64'd1, {63'd0, busy});
    end else begin
      got_exp = sb_q.pop_front();
      check({tag, "_res"}, {hi_out, lo_out}, got_exp);
      m_hi = got_exp[63:32];
      m_lo = got_exp[31:0];
    end
  endtask

  // Op code that must have no effect at all.
  task automatic run_noop(input string tag, input logic [3:0] op);
    @(negedge clk);
    start = 1'b1; mdu_op = op; src_a = 32'd1; src_b = 32'd1;
    #1 check({tag, "_hz"}, {63'd0, md_hazard}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
      @(negedge clk);
    end
    check({tag, "_hilo"}, {hi_out, lo_out}, {m_hi, m_lo});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    longint      sa;
    longint      sbv;
    int          bc;

    reset = 1'b1; start = 1'b0; mdu_op = '0; src_a = '0; src_b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hz", {63'd0, md_hazard}, 64'd0);
    check("rst_hilo", {hi_out, lo_out}, 64'd0);
    reset = 1'b0;

    run_mt("mthi_pre", MDU_MTHI, 32'h11111111);
    run_md("mult_neg", MDU_MULT, 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB}, 5, 0);
    run_md("divu", MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 10, 0);
    run_md("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 10, 0);
    run_md("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 10, 0);
    run_mt("mthi_d0", MDU_MTHI, 32'h12345678);
    run_md("div0", MDU_DIV, 32'd5, 32'd0, {32'h12345678, 32'h80000000}, 10, 0);
    run_md("divu0", MDU_DIVU, 32'd9, 32'd0, {32'h12345678, 32'h80000000}, 10, 0);

    for (int k = 0; k < 3; k++) begin
      ra = $urandom; rb = $urandom;
      run_md("multu_rnd", MDU_MULTU, ra, rb, {32'd0, ra} * {32'd0, rb}, 5, 0);
      ra = $urandom; rb = $urandom;
      sa = longint'($signed(ra)); sbv = longint'($signed(rb));
      run_md("mult_rnd", MDU_MULT, ra, rb, 64'(sa * sbv), 5, 0);
    end

    run_md("intrude", MDU_MULT, 32'd6, 32'd7, {32'd0, 32'd42}, 5, 2);

    // Reset mid-operation discards the in-flight result.
    @(negedge clk);
    start = 1'b1; mdu_op = MDU_MULT; src_a = 32'd3; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    bc = 1;
    while (bc < 3) begin
      @(negedge clk);
      bc++;
    end
    check("rstmid_busy_pre", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_hilo", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (8) @(negedge clk);
    check("rstmid_nocommit", {hi_out, lo_out}, 64'd0);
    check("rstmid_idle", {63'd0, busy}, 64'd0);

    run_mt("mtlo", MDU_MTLO, 32'hAAAA5555);
    check("mtlo_busy_late", {63'd0, busy}, 64'd0);

    run_mt("mthi_acc", MDU_MTHI, 32'h0);
    run_mt("mtlo_acc", MDU_MTLO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_md("maddu", MDU_MADDU, 32'd1, 32'd1, {32'd1, 32'd0}, 5, 0);
    run_md("msub", MDU_MSUB, 32'd2, 32'hFFFFFFFF, {32'd1, 32'd2}, 5, 0);
`else
    run_noop("maddu_undef", MDU_MADDU);
`endif
    run_noop("op_undef", 4'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
